// File: rtl/write_receiver.sv
// Stores one framed packet beat-by-beat into SRAM, chains its blocks and enqueues a descriptor on end of packet.
// Writes, links and the enqueue are registered one cycle after the sampling edge; wr_ready drops while no free address exists.
module write_receiver #(
  parameter int num_of_priorities  = 8,
  parameter int priority_width     = 3,
  parameter int address_width      = 17,
  parameter int arbiter_data_width = 64,
  parameter int max_pkt_words      = 64,
  parameter int len_width          = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_sop,
  input  logic [priority_width-1:0]     wr_prio,
  input  logic                          wr_vld,
  input  logic [arbiter_data_width-1:0] wr_data,
  input  logic                          wr_eop,
  output logic                          wr_ready,
  input  logic                          free_vld,
  input  logic [address_width-1:0]      free_addr,
  output logic                          free_pop,
  output logic                          wea,
  output logic [address_width-1:0]      addra,
  output logic [arbiter_data_width-1:0] dina,
  output logic                          link_we,
  output logic [address_width-1:0]      link_from,
  output logic [address_width-1:0]      link_to,
  output logic                          enq_vld,
  output logic [priority_width-1:0]     enq_prio,
  output logic [address_width-1:0]      enq_head,
  output logic [address_width-1:0]      enq_tail,
  output logic [len_width-1:0]          enq_len,
  output logic [15:0]                   pkt_cnt,
  output logic [15:0]                   err_cnt,
  output logic                          busy
);

  typedef enum logic {IDLE, DATA} state_t;

  localparam logic [len_width-1:0] max_len = len_width'(max_pkt_words);

  if (num_of_priorities > (1 << priority_width)) begin : g_prio_cfg_check
    $error("write_receiver: priority_width too narrow for num_of_priorities");
  end

  state_t                    state, next_state;
  logic [priority_width-1:0] prio;
  logic [address_width-1:0]  head, tail;
  logic [len_width-1:0]      len, final_len;
  logic                      trunc;
  logic                      accept, store, trunc_hit, close, restart;
  logic [1:0]                err_inc;
  logic [address_width-1:0]  final_head, final_tail;

  always_comb begin
    next_state = state;
    store      = 1'b0;
    trunc_hit  = 1'b0;
    close      = 1'b0;
    restart    = 1'b0;
    err_inc    = 2'd0;
    wr_ready   = (state == DATA) && free_vld;
    accept     = wr_vld && wr_ready;
    case (state)
      IDLE: begin
        if (wr_vld || wr_eop) err_inc = 2'd1;
        if (wr_sop) begin
          restart    = 1'b1;
          next_state = DATA;
        end
      end
      DATA: begin
        store     = accept && (len < max_len);
        trunc_hit = accept && !store;
        // An early sop closes the old packet; a same-cycle beat still belongs to it.
        if (wr_sop) begin
          close   = 1'b1;
          restart = 1'b1;
        end else if (wr_eop) begin
          close      = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    free_pop   = store;
    final_len  = store ? len + len_width'(1) : len;
    final_head = (len == '0) ? free_addr : head;
    final_tail = store ? free_addr : tail;
    err_inc    = err_inc + 2'(trunc_hit && !trunc) + 2'(close && (final_len == '0))
               + 2'((state == DATA) && wr_sop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= '0;
      head      <= '0;
      tail      <= '0;
      len       <= '0;
      trunc     <= 1'b0;
      wea       <= 1'b0;
      addra     <= '0;
      dina      <= '0;
      link_we   <= 1'b0;
      link_from <= '0;
      link_to   <= '0;
      enq_vld   <= 1'b0;
      enq_prio  <= '0;
      enq_head  <= '0;
      enq_tail  <= '0;
      enq_len   <= '0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      state   <= next_state;
      wea     <= store;
      link_we <= store && (len != '0);
      if (store) begin
        addra     <= free_addr;
        dina      <= wr_data;
        link_from <= tail;
        link_to   <= free_addr;
        tail      <= free_addr;
        if (len == '0) head <= free_addr;
      end
      enq_vld <= close && (final_len != '0);
      if (close && (final_len != '0)) begin
        enq_prio <= prio;
        enq_head <= final_head;
        enq_tail <= final_tail;
        enq_len  <= final_len;
        pkt_cnt  <= pkt_cnt + 16'd1;
      end
      err_cnt <= err_cnt + 16'(err_inc);
      if (restart) begin
        prio  <= wr_prio;
        len   <= '0;
        trunc <= 1'b0;
      end else begin
        if (close) len <= '0;
        else if (store) len <= final_len;
        if (trunc_hit) trunc <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_write_receiver.sv
// Scoreboard bench for write_receiver: a reference model queues expected SRAM writes, links and descriptors.
module tb_write_receiver;
  localparam int AW = 17, DW = 64, PW = 3, LW = 7, MAXW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_sop, wr_vld, wr_eop, wr_ready, free_vld, free_pop;
  logic [PW-1:0] wr_prio, enq_prio;
  logic [DW-1:0] wr_data, dina;
  logic [AW-1:0] free_addr, addra, link_from, link_to, enq_head, enq_tail;
  logic          wea, link_we, enq_vld, busy;
  logic [LW-1:0] enq_len;
  logic [15:0]   pkt_cnt, err_cnt;

  always #5 clk = ~clk;

  write_receiver dut (
    .clk(clk), .rst(rst), .wr_sop(wr_sop), .wr_prio(wr_prio), .wr_vld(wr_vld),
    .wr_data(wr_data), .wr_eop(wr_eop), .wr_ready(wr_ready), .free_vld(free_vld),
    .free_addr(free_addr), .free_pop(free_pop), .wea(wea), .addra(addra), .dina(dina),
    .link_we(link_we), .link_from(link_from), .link_to(link_to), .enq_vld(enq_vld),
    .enq_prio(enq_prio), .enq_head(enq_head), .enq_tail(enq_tail), .enq_len(enq_len),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .busy(busy)
  );

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct packed { logic [AW-1:0] from; logic [AW-1:0] to; } ln_t;
  typedef struct packed { logic [PW-1:0] prio; logic [AW-1:0] head; logic [AW-1:0] tail; logic [LW-1:0] len; } enq_t;

  wr_t  wq[$];
  ln_t  lq[$];
  enq_t eq[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // reference model state
  bit            in_pkt = 0;
  int            m_len = 0;
  bit            m_trunc = 0;
  logic [AW-1:0] m_head = '0, m_tail = '0, next_free = '0;
  logic [PW-1:0] m_prio = '0;
  logic [15:0]   m_err = '0, m_pkt = '0;

  logic [PW-1:0] last_prio = '0;
  logic [AW-1:0] last_head = '0, last_tail = '0;
  logic [LW-1:0] last_len = '0;

  wr_t  mw;
  ln_t  ml;
  enq_t me;

  always @(negedge clk) begin
    if (!rst) begin
      chk("wea", 64'(wea), 64'(wq.size() != 0));
      if (wq.size() != 0) begin
        mw = wq.pop_front();
        if (wea) begin
          chk("addra", 64'(addra), 64'(mw.addr));
          chk("dina", dina, mw.data);
        end
      end
      chk("link_we", 64'(link_we), 64'(lq.size() != 0));
      if (lq.size() != 0) begin
        ml = lq.pop_front();
        if (link_we) begin
          chk("link_from", 64'(link_from), 64'(ml.from));
          chk("link_to", 64'(link_to), 64'(ml.to));
        end
      end
      chk("enq_vld", 64'(enq_vld), 64'(eq.size() != 0));
      if (eq.size() != 0) begin
        me = eq.pop_front();
        if (enq_vld) begin
          chk("enq_prio", 64'(enq_prio), 64'(me.prio));
          chk("enq_head", 64'(enq_head), 64'(me.head));
          chk("enq_tail", 64'(enq_tail), 64'(me.tail));
          chk("enq_len", 64'(enq_len), 64'(me.len));
        end
      end
      if (enq_vld) begin
        last_prio = enq_prio;
        last_head = enq_head;
        last_tail = enq_tail;
        last_len  = enq_len;
      end
    end
  end

  // One cycle of stimulus; expectations are queued after the edge so the next negedge sees them.
  task automatic step(input bit sop, input logic [PW-1:0] prio, input bit vld,
                      input logic [DW-1:0] data, input bit eop, input bit fv);
    bit rdy, acc, st, pw, pl, pe;
    int errd;
    wr_t wv; ln_t lv; enq_t ev;
    wr_sop = sop; wr_prio = prio; wr_vld = vld; wr_data = data; wr_eop = eop;
    free_vld = fv; free_addr = next_free;
    #1;
    rdy = in_pkt && fv;
    acc = vld && rdy;
    st  = acc && (m_len < MAXW);
    chk("wr_ready", 64'(wr_ready), 64'(rdy));
    chk("free_pop", 64'(free_pop), 64'(st));
    chk("busy", 64'(busy), 64'(in_pkt));
    errd = 0; pw = 0; pl = 0; pe = 0;
    wv = '0; lv = '0; ev = '0;
    if (!in_pkt) begin
      if (vld || eop) errd = 1;
      if (sop) begin in_pkt = 1; m_prio = prio; m_len = 0; m_trunc = 0; end
    end else begin
      if (st) begin
        pw = 1; wv = '{next_free, data};
        if (m_len == 0) m_head = next_free;
        else begin pl = 1; lv = '{m_tail, next_free}; end
        m_tail = next_free;
        m_len++;
        next_free++;
      end else if (acc && !m_trunc) begin
        m_trunc = 1; errd++;
      end
      if (sop || eop) begin
        if (m_len > 0) begin
          pe = 1; ev = '{m_prio, m_head, m_tail, LW'(m_len)}; m_pkt++;
        end else errd++;
        if (sop) begin errd++; m_prio = prio; m_len = 0; m_trunc = 0; end
        else in_pkt = 0;
      end
    end
    m_err += 16'(errd);
    @(posedge clk); #1;
    if (pw) wq.push_back(wv);
    if (pl) lq.push_back(lv);
    if (pe) eq.push_back(ev);
    chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
    chk("err_cnt", 64'(err_cnt), 64'(m_err));
  endtask

  task automatic do_reset(input int n);
    @(negedge clk); #1;
    rst = 1; wr_sop = 0; wr_eop = 0; wr_vld = 1; free_vld = 1; wr_prio = '1;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_wea", 64'(wea), 0);         chk("rst_addra", 64'(addra), 0);
    chk("rst_dina", dina, 0);            chk("rst_link_we", 64'(link_we), 0);
    chk("rst_link_from", 64'(link_from), 0); chk("rst_link_to", 64'(link_to), 0);
    chk("rst_enq_vld", 64'(enq_vld), 0); chk("rst_enq_head", 64'(enq_head), 0);
    chk("rst_enq_tail", 64'(enq_tail), 0); chk("rst_enq_len", 64'(enq_len), 0);
    chk("rst_enq_prio", 64'(enq_prio), 0); chk("rst_pkt_cnt", 64'(pkt_cnt), 0);
    chk("rst_err_cnt", 64'(err_cnt), 0); chk("rst_busy", 64'(busy), 0);
    chk("rst_wr_ready", 64'(wr_ready), 0); chk("rst_free_pop", 64'(free_pop), 0);
    wr_vld = 0; free_vld = 0; wr_prio = '0;
    rst = 0;
    in_pkt = 0; m_len = 0; m_trunc = 0; m_err = '0; m_pkt = '0;
    wq.delete(); lq.delete(); eq.delete();
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  logic [DW-1:0] d;
  logic [15:0]   err_before, pkt_before;

  initial begin
    wr_sop = 0; wr_vld = 0; wr_eop = 0; wr_prio = '0; wr_data = '0;
    free_vld = 0; free_addr = '0;
    do_reset(3);

    // basic packet
    next_free = 17'd10;
    step(1, 3'd5, 0, '0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 1, rnd(), 0, 1);
    step(0, '0, 0, '0, 1, 1);
    step(0, '0, 0, '0, 0, 1);
    chk("basic_prio", 64'(last_prio), 5);
    chk("basic_head", 64'(last_head), 10);
    chk("basic_tail", 64'(last_tail), 12);
    chk("basic_len", 64'(last_len), 3);
    chk("basic_pkt_cnt", 64'(pkt_cnt), 1);

    // backpressure with held beat, eop on last beat
    step(1, 3'd2, 0, '0, 0, 1);
    step(0, '0, 1, rnd(), 0, 1);
    d = rnd();
    step(0, '0, 1, d, 0, 0);
    step(0, '0, 1, d, 0, 0);
    step(0, '0, 1, d, 0, 1);
    step(0, '0, 1, rnd(), 1, 1);
    step(0, '0, 0, '0, 0, 1);
    chk("bp_len", 64'(last_len), 3);

    // truncation
    err_before = err_cnt;
    step(1, 3'd7, 0, '0, 0, 1);
    for (int i = 0; i < MAXW + 2; i++) step(0, '0, 1, rnd(), 0, 1);
    step(0, '0, 0, '0, 1, 1);
    step(0, '0, 0, '0, 0, 1);
    chk("trunc_len", 64'(last_len), 64);
    chk("trunc_err_delta", 64'(err_cnt - err_before), 1);

    // protocol errors
    err_before = err_cnt; pkt_before = pkt_cnt;
    step(1, 3'd3, 0, '0, 0, 1);
    step(0, '0, 0, '0, 1, 1);
    step(0, '0, 1, rnd(), 0, 1);
    step(0, '0, 0, '0, 0, 1);
    chk("err_delta", 64'(err_cnt - err_before), 2);
    chk("err_no_pkt", 64'(pkt_cnt - pkt_before), 0);

    // early restart, then sop in the enq_vld cycle
    step(1, 3'd1, 0, '0, 0, 1);
    step(0, '0, 1, rnd(), 0, 1);
    step(0, '0, 1, rnd(), 0, 1);
    step(1, 3'd4, 1, rnd(), 0, 1);
    step(0, '0, 1, rnd(), 0, 1);
    step(0, '0, 1, rnd(), 0, 1);
    step(0, '0, 0, '0, 1, 1);
    step(1, 3'd6, 0, '0, 0, 1);
    chk("restart_prio", 64'(last_prio), 4);
    chk("restart_len", 64'(last_len), 2);
    step(0, '0, 1, rnd(), 0, 1);
    step(0, '0, 1, rnd(), 1, 1);
    step(0, '0, 0, '0, 0, 1);
    chk("b2b_prio", 64'(last_prio), 6);
    chk("b2b_len", 64'(last_len), 2);

    // reset mid-packet
    step(1, 3'd2, 0, '0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 1, rnd(), 0, 1);
    do_reset(2);
    step(0, '0, 0, '0, 1, 1);
    step(0, '0, 0, '0, 0, 1);
    chk("post_rst_err", 64'(err_cnt), 1);

    step(0, '0, 0, '0, 0, 0);
    chk("wq_drained", 64'(wq.size()), 0);
    chk("lq_drained", 64'(lq.size()), 0);
    chk("eq_drained", 64'(eq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/write_receiver.md
# write_receiver

Ingress-side counterpart of the SRAM read path: accepts one packet stream framed as `wr_sop` / `wr_vld` / `wr_eop`. For each data beat it pops a free SRAM block address, writes the beat to SRAM port A, and builds the packet's linked list. On end of packet it hands a descriptor (priority, head, tail, length) to the per-priority queue manager, which later feeds the read arbiter.

## Interface
- `num_of_priorities`, 8, number of priority queues
- `priority_width`, 3, width of priority field
- `address_width`, 17, SRAM block address width
- `arbiter_data_width`, 64, data beat width
- `max_pkt_words`, 64, maximum beats stored per packet
- `len_width`, 7, packet length width (holds 0..max_pkt_words)

Ports (reset `rst` is synchronous, active-high; clock `clk`):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `wr_sop`  in  1  one-cycle start pulse, precedes first beat
- `wr_prio`  in  priority_width  packet priority, sampled with `wr_sop`
- `wr_vld`  in  1  data beat valid
- `wr_data`  in  arbiter_data_width  data beat
- `wr_eop`  in  1  one-cycle end pulse, with or after last beat
- `wr_ready`  out  1  beat accepted when `wr_vld & wr_ready`
- `free_vld`  in  1  free-address list non-empty (show-ahead)
- `free_addr`  in  address_width  head of free-address list
- `free_pop`  out  1  consume `free_addr` this cycle
- `wea`  out  1  SRAM write enable
- `addra`  out  address_width  SRAM write address
- `dina`  out  arbiter_data_width  SRAM write data
- `link_we`  out  1  linked-list write strobe
- `link_from`  out  address_width  previous beat address
- `link_to`  out  address_width  next beat address
- `enq_vld`  out  1  descriptor valid pulse
- `enq_prio`  out  priority_width  descriptor priority
- `enq_head`  out  address_width  first beat address
- `enq_tail`  out  address_width  last beat address
- `enq_len`  out  len_width  beats stored
- `pkt_cnt`  out  16  packets enqueued, wraps
- `err_cnt`  out  16  protocol errors and truncations, wraps
- `busy`  out  1  state != IDLE

## Operation
- **FSM:** IDLE, DATA.
- **IDLE:**
  - `wr_sop` latches `wr_prio`, sets `len`=0 and `trunc`=0, and moves to DATA.
  - `wr_vld` or `wr_eop` seen in IDLE is ignored and increments `err_cnt`.
- **Beat acceptance:**
  - `wr_ready` = (state==DATA) & `free_vld`, combinational.
  - `free_pop` = `wr_vld` & `wr_ready` & (`len` < `max_pkt_words`).
- **Per stored beat (registered):**
  - `wea`=1, `addra`=`free_addr`, `dina`=`wr_data`.
  - First beat: `head` <= `free_addr`. Later beats: `link_we`=1, `link_from`=`tail`, `link_to`=`free_addr`.
  - Every beat: `tail` <= `free_addr`, `len`++.
- **Truncation:** a beat accepted while `len`==`max_pkt_words` is discarded. It causes no pop, no write and no link. It sets `trunc`, and `err_cnt`++ happens once per packet.
- **End of packet:** `wr_eop` in DATA with final `len`>0 pulses `enq_vld` with `{prio, head, tail, len}`, increments `pkt_cnt`, and returns to IDLE.
  - If `wr_vld` and `wr_eop` coincide, that beat is included.
  - Final `len`==0: no enqueue, `err_cnt`++, return to IDLE.
- **Early restart:** `wr_sop` in DATA closes the current packet as if `wr_eop` arrived, and also increments `err_cnt`. It then relatches `wr_prio`, zeroes `len`, and stays in DATA. A simultaneous `wr_vld` beat belongs to the old packet.
- **Arithmetic:** `len` never exceeds `max_pkt_words`. Both counters are modulo 2^16.

## Timing
- **Reset values:** every output register is 0, state is IDLE, and `head`, `tail`, `len`, `trunc` and the latched priority are 0. With state IDLE, the combinational `wr_ready` and `free_pop` are 0.
- **Mid-packet reset:** a packet in progress is abandoned, with no enqueue. Addresses already popped are not returned.
- **Latency:**
  - Beat accepted at edge E: `wea`/`link_we` asserted in the cycle after E, for one cycle.
  - `wr_eop` sampled at edge E: `enq_vld` high for one cycle after E.
  - The last `wea` is never later than `enq_vld`.
- **Start of data:** the earliest beat after `wr_sop` is sampled one edge after the `wr_sop` edge.
- **Back-to-back:** `wr_sop` is legal in the cycle `enq_vld` is high.
- **Backpressure:** with `free_vld`=0, `wr_ready`=0. The sender holds `wr_vld`/`wr_data`, and `wr_eop` may still be sampled.

## Test plan
- **Basic packet:** `wr_sop` with prio=5, 3 beats on free addresses 10, 11, 12, `wr_eop` a cycle later. Expect `wea` at 10/11/12, links 10->11 and 11->12, one `enq_vld` with {5, 10, 12, 3}, `pkt_cnt`=1.
- **Backpressure:** `free_vld` low for 2 cycles mid-packet. Expect `wr_ready`=0 with no pop or write during the stall, and data order intact.
- **Truncation:** 66 beats with `max_pkt_words`=64. Expect 64 writes, `enq_len`=64, `err_cnt`=1.
- **Errors:** `wr_eop` right after `wr_sop` gives no enqueue and `err_cnt`++. `wr_vld` in IDLE gives `err_cnt`++.
- **Early restart and back-to-back:** `wr_sop` mid-packet enqueues the old packet, and the new packet uses the new priority. `wr_sop` in the `enq_vld` cycle is accepted.
- **Reset:** reset asserted mid-packet clears all outputs and suppresses the enqueue.
